lap_dump_uart: RTL
==================

Name: lap_dump_uart

Overview:
- Reads every stored lap time out of the stopwatch lap memory on request.
- Formats each entry as ASCII text and sends it out a UART TX pin (8N1) to a host terminal.
- It is the reader and exporter for the 16-bit BCD lap memory: it consumes the memory's read port and produces a serial stream.
- Sits beside the display path in the top level, clocked by the 50 MHz board clock.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (434 at defaults).
- NUM_ENTRIES, 4, number of memory entries dumped per request.
- ADDR_W, 2, memory address width; NUM_ENTRIES <= 2**ADDR_W.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse requesting a full dump; ignored while busy=1.
- mem_read_address  out  ADDR_W  read address to lap memory; top level routes it to memory while busy=1.
- mem_data  in  16  memory read data {s_dez, s_uni, cs_dez, cs_uni}, BCD nibbles.
- uart_tx  out  1  serial output, idle high.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last stop bit of the last entry.

Behaviour:
- Reset values: uart_tx=1, busy=0, done=0, mem_read_address=0, FSM=IDLE. Reset takes effect at the next clock edge.
- Reset mid-transfer aborts immediately. uart_tx returns high on that edge; no partial byte completion.
- FSM states: IDLE, SET_ADDR, WAIT_MEM, LATCH, LOAD_CHAR, TX_START, TX_DATA, TX_STOP, NEXT_CHAR, NEXT_ENTRY, FINISH.
- IDLE: if start=1, set entry index=0 and go to SET_ADDR. busy rises on the next cycle.
- SET_ADDR: drive mem_read_address=index, then go to WAIT_MEM.
- WAIT_MEM: hold for exactly 2 cycles. This covers both combinational and 1-cycle registered memory reads.
- LATCH: capture mem_data into an internal 16-bit register. Memory changes after this point do not affect the current entry.
- Entry text is 9 bytes, sent in order: '0'+index, ':', s_dez, s_uni, '.', cs_dez, cs_uni, 0x0D, 0x0A.
- Digit conversion: nibble 0-9 maps to 0x30+nibble; nibble 10-15 maps to '?' (0x3F).
- Byte framing: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles, so one byte = 10*CLKS_PER_BIT cycles.
- Byte spacing: back-to-back, no idle gap between bytes. LOAD_CHAR and NEXT_CHAR are absorbed within the stop-bit period, so the stop bit is not lengthened.
- Byte position counter: 0..8. After byte 8, go to NEXT_ENTRY.
- NEXT_ENTRY: if index = NUM_ENTRIES-1, go to FINISH; otherwise index+1 and go to SET_ADDR. uart_tx stays 1 during the memory fetch gap (5 cycles).
- FINISH: done=1 for one cycle, busy=0, mem_read_address returns to 0, then IDLE.
- start while busy: ignored, no queuing.
- start in the same cycle as the FINISH cycle: ignored.
- Address wrap: index never exceeds NUM_ENTRIES-1; no wrap is generated.
- Dump length at defaults: 36 bytes = 36*4340 cycles, plus 4 fetch gaps.

Test Plan:
- Baud timing: preload entry0=0x1234, pulse start → first falling edge of uart_tx is a start bit 434 cycles wide; decoded bytes are "0:12.34\r\n"; every bit is 434±0 cycles.
- Full dump: memory = {0x0000, 0x5999, 0x0107, 0x4200} → host decodes "0:00.00\r\n1:59.99\r\n2:01.07\r\n3:42.00\r\n". done pulses once, 1 cycle, after the final stop bit. busy is high for the whole dump.
- Invalid BCD: entry1=0xA0F3 → line "1:?0.?3\r\n"; all other lines unaffected.
- start while busy: pulse start again during entry 2 → exactly 36 bytes sent, one done pulse, and a new dump starts only after a start issued post-done.
- Data change after latch: overwrite entry0 to 0x9999 during its 3rd byte → line still "0:12.34"; a second dump shows "0:99.99".
- Reset mid-byte: assert reset during data bit 3 of byte 4 → uart_tx=1, busy=0 on the next edge; a subsequent start gives a complete, correct dump from entry 0.

Source files
------------

// File: rtl/lap_dump_uart.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lap_dump_uart                                                 |
// | Purpose  : Reads every entry of the 16-bit BCD lap memory on request,    |
// |            formats it as "<n>:SS.CC\r\n" and sends it out an 8N1 UART.   |
// | Ports    : clock_i            system clock                                |
// |            reset_i            synchronous active-high reset               |
// |            start_i            one-cycle dump request (ignored while busy) |
// |            mem_read_address_o lap memory read address                     |
// |            mem_data_i         lap memory read data {sD,sU,cD,cU}          |
// |            uart_tx_o          serial output, idle high                    |
// |            busy_o             dump in progress                            |
// |            done_o             one-cycle pulse after the last stop bit     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module lap_dump_uart #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 115200,
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_W      = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] mem_read_address_o,
  input  logic [15:0]       mem_data_i,
  output logic              uart_tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  // TX_STOP is two cycles short: NEXT_CHAR plus LOAD_CHAR (or NEXT_ENTRY
  // on the last byte of an entry) complete the stop bit at line level high.
  localparam logic [CNT_W-1:0]  C_STOP_LAST = CNT_W'(CLKS_PER_BIT - 3);
  localparam logic [ADDR_W-1:0] C_LAST_IDX  = ADDR_W'(NUM_ENTRIES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SET_ADDR, S_WAIT_MEM, S_LATCH, S_LOAD_CHAR, S_TX_START,
    S_TX_DATA, S_TX_STOP, S_NEXT_CHAR, S_NEXT_ENTRY, S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [2:0]          bit_q,   bit_d;
  logic [3:0]          pos_q,   pos_d;
  logic [ADDR_W-1:0]   idx_q,   idx_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [15:0]         lat_q,   lat_d;
  logic [7:0]          ch_q,    ch_d;
  logic [7:0]          char_sel;

  // BCD nibble to ASCII digit; non-decimal codes are shown as '?'.
  function automatic logic [7:0] bcd_char(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
  endfunction

  always_comb begin
    char_sel = 8'h0A;
    case (pos_q)
      4'd0:    char_sel = 8'h30 + 8'(idx_q);
      4'd1:    char_sel = 8'h3A;
      4'd2:    char_sel = bcd_char(lat_q[15:12]);
      4'd3:    char_sel = bcd_char(lat_q[11:8]);
      4'd4:    char_sel = 8'h2E;
      4'd5:    char_sel = bcd_char(lat_q[7:4]);
      4'd6:    char_sel = bcd_char(lat_q[3:0]);
      4'd7:    char_sel = 8'h0D;
      default: char_sel = 8'h0A;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    pos_d   = pos_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d   = '0;
          state_d = S_SET_ADDR;
        end
      end
      S_SET_ADDR: begin
        addr_d  = idx_q;
        state_d = S_WAIT_MEM;
      end
      S_WAIT_MEM: begin
        if (cnt_q == CNT_W'(1)) state_d = S_LATCH;
      end
      S_LATCH: begin
        lat_d   = mem_data_i;
        pos_d   = '0;
        state_d = S_LOAD_CHAR;
      end
      S_LOAD_CHAR: begin
        ch_d    = char_sel;
        bit_d   = '0;
        state_d = S_TX_START;
      end
      S_TX_START: begin
        if (cnt_q == C_BIT_LAST) state_d = S_TX_DATA;
      end
      S_TX_DATA: begin
        // Several bits share this state, so the bit timer restarts here.
        if (cnt_q == C_BIT_LAST) begin
          cnt_d = '0;
          ch_d  = {1'b0, ch_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_TX_STOP;
        end
      end
      S_TX_STOP: begin
        if (cnt_q == C_STOP_LAST) state_d = S_NEXT_CHAR;
      end
      S_NEXT_CHAR: begin
        if (pos_q == 4'd8) begin
          state_d = S_NEXT_ENTRY;
        end else begin
          pos_d   = pos_q + 1'b1;
          state_d = S_LOAD_CHAR;
        end
      end
      S_NEXT_ENTRY: begin
        if (idx_q == C_LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SET_ADDR;
        end
      end
      S_FINISH: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      pos_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      lat_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      pos_q   <= pos_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      ch_q    <= ch_d;
    end
  end

  // Line level is a pure decode of registered state, so a reset forces it
  // high on the same edge that aborts the transfer.
  assign uart_tx_o          = (state_q == S_TX_START) ? 1'b0 :
                              (state_q == S_TX_DATA)  ? ch_q[0] : 1'b1;
  assign busy_o             = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done_o             = (state_q == S_FINISH);
  assign mem_read_address_o = addr_q;

endmodule
`default_nettype wire
